polyphase_interp_fir: RTL and testbench

- Single-clock 1:2 polyphase interpolation FIR: the recombining counterpart of the even/odd polyphase split path.
- Accepts one input sample per handshake and computes both sub-filter phases in parallel:
  - even phase uses taps h0/h2;
  - odd phase uses taps h1/h3.
- Serializes the two phase results into one output stream at twice the input sample rate: even sample first, then odd.
- Sits after the per-phase processing, where the team needs a full-rate merged stream back on one clock without a CDC FIFO.

---
 rtl/polyphase_interp_fir.sv | 169 ++++++++++++++++
 tb/tb_polyphase_interp_fir.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_interp_fir.sv
// polyphase_interp_fir
// 1:2 polyphase interpolation FIR. Each accepted input sample produces two
// output samples: the even phase (taps H0/H2) first, then the odd phase
// (taps H1/H3). Both phases are computed in the accept cycle. The odd
// result waits in a hold register until the even sample has been consumed.
module polyphase_interp_fir #(
    parameter int                       DATA_W = 16,
    parameter logic signed [DATA_W-1:0] H0     = 16'sd1,
    parameter logic signed [DATA_W-1:0] H1     = 16'sd2,
    parameter logic signed [DATA_W-1:0] H2     = 16'sd3,
    parameter logic signed [DATA_W-1:0] H3     = 16'sd4,
    parameter int                       SHIFT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_phase,
    output logic              out_sat
);

    // Product and sum widths. The sum width holds the sum of two full
    // products, so the adder cannot overflow internally.
    localparam int PW = 2 * DATA_W;
    localparam int SW = 2 * DATA_W + 1;

    // Saturation bounds, expressed at sum width.
    localparam logic signed [SW-1:0] SAT_MAX =
        {{(DATA_W + 1){1'b0}}, 1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

    // Taps sign-extended to product width, so that every multiply runs at full width.
    localparam logic signed [PW-1:0] H0_E = {{DATA_W{H0[DATA_W-1]}}, H0};
    localparam logic signed [PW-1:0] H1_E = {{DATA_W{H1[DATA_W-1]}}, H1};
    localparam logic signed [PW-1:0] H2_E = {{DATA_W{H2[DATA_W-1]}}, H2};
    localparam logic signed [PW-1:0] H3_E = {{DATA_W{H3[DATA_W-1]}}, H3};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVEN = 2'd1,
        S_ODD  = 2'd2
    } state_t;

    // Clip a shifted phase sum to the output range.
    // The result is {clipped_flag, sample}.
    function automatic logic [DATA_W:0] sat_fn(input logic signed [SW-1:0] v);
        logic [DATA_W:0] res;
        if (v > SAT_MAX) begin
            res = {1'b1, SAT_MAX[DATA_W-1:0]};
        end else if (v < SAT_MIN) begin
            res = {1'b1, SAT_MIN[DATA_W-1:0]};
        end else begin
            res = {1'b0, v[DATA_W-1:0]};
        end
        return res;
    endfunction

    state_t                   r_state;
    logic        [DATA_W-1:0] r_x_d1;
    logic        [DATA_W-1:0] r_odd_data;
    logic                     r_odd_sat;

    logic signed [PW-1:0]     w_x_ext;
    logic signed [PW-1:0]     w_xd_ext;
    logic signed [PW-1:0]     w_p0;
    logic signed [PW-1:0]     w_p1;
    logic signed [PW-1:0]     w_p2;
    logic signed [PW-1:0]     w_p3;
    logic signed [SW-1:0]     w_sum_even;
    logic signed [SW-1:0]     w_sum_odd;
    logic signed [SW-1:0]     w_shift_even;
    logic signed [SW-1:0]     w_shift_odd;
    logic        [DATA_W:0]   w_even_res;
    logic        [DATA_W:0]   w_odd_res;
    logic                     w_accept;

    // Current sample and history sample, sign-extended to product width.
    assign w_x_ext  = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    assign w_xd_ext = {{DATA_W{r_x_d1[DATA_W-1]}}, r_x_d1};

    // Both phases are evaluated in parallel from the same pair of samples.
    assign w_p0 = w_x_ext  * H0_E;
    assign w_p1 = w_x_ext  * H1_E;
    assign w_p2 = w_xd_ext * H2_E;
    assign w_p3 = w_xd_ext * H3_E;

    assign w_sum_even = {w_p0[PW-1], w_p0} + {w_p2[PW-1], w_p2};
    assign w_sum_odd  = {w_p1[PW-1], w_p1} + {w_p3[PW-1], w_p3};

    assign w_shift_even = w_sum_even >>> SHIFT;
    assign w_shift_odd  = w_sum_odd  >>> SHIFT;

    assign w_even_res = sat_fn(w_shift_even);
    assign w_odd_res  = sat_fn(w_shift_odd);

    // A new sample is taken when idle, or when the odd sample leaves the
    // block. The second case gives back-to-back operation without a bubble.
    assign in_ready = (r_state == S_IDLE) || ((r_state == S_ODD) && out_ready);
    assign w_accept = in_valid && in_ready;

    // Sequencer: loads both phases on accept, serializes even then odd,
    // and holds every output stable while the downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_x_d1     <= {DATA_W{1'b0}};
            r_odd_data <= {DATA_W{1'b0}};
            r_odd_sat  <= 1'b0;
            out_data   <= {DATA_W{1'b0}};
            out_valid  <= 1'b0;
            out_phase  <= 1'b0;
            out_sat    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        out_data   <= w_even_res[DATA_W-1:0];
                        out_sat    <= w_even_res[DATA_W];
                        r_odd_data <= w_odd_res[DATA_W-1:0];
                        r_odd_sat  <= w_odd_res[DATA_W];
                        r_x_d1     <= in_data;
                        out_valid  <= 1'b1;
                        out_phase  <= 1'b0;
                        r_state    <= S_EVEN;
                    end
                end
                S_EVEN: begin
                    if (out_ready) begin
                        out_data  <= r_odd_data;
                        out_sat   <= r_odd_sat;
                        out_phase <= 1'b1;
                        r_state   <= S_ODD;
                    end
                end
                S_ODD: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            out_data   <= w_even_res[DATA_W-1:0];
                            out_sat    <= w_even_res[DATA_W];
                            r_odd_data <= w_odd_res[DATA_W-1:0];
                            r_odd_sat  <= w_odd_res[DATA_W];
                            r_x_d1     <= in_data;
                            out_valid  <= 1'b1;
                            out_phase  <= 1'b0;
                            r_state    <= S_EVEN;
                        end else begin
                            out_valid <= 1'b0;
                            out_phase <= 1'b0;
                            out_sat   <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    out_phase <= 1'b0;
                    out_sat   <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_polyphase_interp_fir.sv
// Bench for polyphase_interp_fir. It uses directed per-cycle vector tables,
// hand-written reset and SHIFT sequences, and randomized traffic that is
// checked against an arithmetic reference model. A second instance
// (SHIFT=2) shares the stimulus.
module tb_polyphase_interp_fir;

    localparam int TH0 = 1;
    localparam int TH1 = 2;
    localparam int TH2 = 3;
    localparam int TH3 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = 16'd0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, out_phase_a, out_sat_a;
    logic [15:0] out_data_a;
    logic        in_ready_b, out_valid_b, out_phase_b, out_sat_b;
    logic [15:0] out_data_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    polyphase_interp_fir #(.DATA_W(16), .SHIFT(0)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_phase(out_phase_a), .out_sat(out_sat_a)
    );

    polyphase_interp_fir #(.DATA_W(16), .SHIFT(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_phase(out_phase_b), .out_sat(out_sat_b)
    );

    typedef struct {
        bit rb;   // reset before this cycle
        bit iv;
        int din;
        bit ordy;
        bit ev;
        int ed;
        bit eph;
        bit es;
        bit eir;
    } vec_t;

    typedef struct {
        int d0;
        bit s0;
        int d2;
        bit s2;
        bit ph;
    } exp_t;

    vec_t vt[$];
    exp_t q[$];
    int   xprev;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference arithmetic: (hc*x + hp*xp) >>> sh, clipped to 16 bits.
    function automatic int ref_y(input int hc, input int hp, input int x,
                                 input int xp, input int sh, output bit s);
        longint v;
        v = longint'(hc) * longint'(x) + longint'(hp) * longint'(xp);
        v = v >>> sh;
        s = 1'b0;
        if (v > 32767) begin
            v = 32767;
            s = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            s = 1'b1;
        end
        return int'(v);
    endfunction

    task automatic add(input bit rb, input bit iv, input int din, input bit ordy,
                       input bit ev, input int ed, input bit eph, input bit es,
                       input bit eir);
        vec_t v;
        v.rb = rb; v.iv = iv; v.din = din; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.eph = eph; v.es = es; v.eir = eir;
        vt.push_back(v);
    endtask

    // One cycle: drive just after the rising edge, then sample on the falling edge.
    task automatic step(input bit iv, input int d, input bit r);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d[15:0];
        out_ready = r;
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input bit which, input bit ev,
                           input int ed, input bit eph, input bit es, input bit eir);
        logic        v, p, s, ir;
        logic [15:0] d;
        if (which) begin
            v = out_valid_b; p = out_phase_b; s = out_sat_b; ir = in_ready_b; d = out_data_b;
        end else begin
            v = out_valid_a; p = out_phase_a; s = out_sat_a; ir = in_ready_a; d = out_data_a;
        end
        chk({tag, ".out_valid"}, v, ev);
        chk({tag, ".in_ready"}, ir, eir);
        if (ev) begin
            chk({tag, ".out_data"}, int'($signed(d)), ed);
            chk({tag, ".out_phase"}, p, eph);
            chk({tag, ".out_sat"}, s, es);
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 16'd0;
        rst       = 1'b1;
        #1;
        chk("reset.out_valid", out_valid_a, 0);
        chk("reset.out_data", out_data_a, 0);
        chk("reset.out_phase", out_phase_a, 0);
        chk("reset.out_sat", out_sat_a, 0);
        chk("reset.in_ready", in_ready_a, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Model check for one sampled cycle, then advance the model across the next edge.
    task automatic model_cycle(input bit iv, input int d, input bit r);
        bit   exp_ir;
        exp_t e;
        int   sz;
        sz     = q.size();
        exp_ir = (sz == 0) || (sz == 1 && r);
        chk("rnd.in_ready", in_ready_a, exp_ir);
        chk("rnd.out_valid", out_valid_a, sz != 0);
        chk("rnd2.out_valid", out_valid_b, sz != 0);
        if (sz != 0) begin
            chk("rnd.out_data", int'($signed(out_data_a)), q[0].d0);
            chk("rnd.out_sat", out_sat_a, q[0].s0);
            chk("rnd.out_phase", out_phase_a, q[0].ph);
            chk("rnd2.out_data", int'($signed(out_data_b)), q[0].d2);
            chk("rnd2.out_sat", out_sat_b, q[0].s2);
            if (r) void'(q.pop_front());
        end
        if (iv && exp_ir) begin
            e.ph = 1'b0;
            e.d0 = ref_y(TH0, TH2, d, xprev, 0, e.s0);
            e.d2 = ref_y(TH0, TH2, d, xprev, 2, e.s2);
            q.push_back(e);
            e.ph = 1'b1;
            e.d0 = ref_y(TH1, TH3, d, xprev, 0, e.s0);
            e.d2 = ref_y(TH1, TH3, d, xprev, 2, e.s2);
            q.push_back(e);
            xprev = d;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Basic: 100 then 10.
        add(1, 1, 100, 1, 0, 0, 0, 0, 1);
        add(0, 1, 10, 1, 1, 100, 0, 0, 0);
        add(0, 1, 10, 1, 1, 200, 1, 0, 1);
        add(0, 0, 0, 1, 1, 310, 0, 0, 0);
        add(0, 0, 0, 1, 1, 420, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1);
        // Back-to-back 1,2,3.
        add(1, 1, 1, 1, 0, 0, 0, 0, 1);
        add(0, 1, 2, 1, 1, 1, 0, 0, 0);
        add(0, 1, 2, 1, 1, 2, 1, 0, 1);
        add(0, 1, 3, 1, 1, 5, 0, 0, 0);
        add(0, 1, 3, 1, 1, 8, 1, 0, 1);
        add(0, 0, 0, 1, 1, 9, 0, 0, 0);
        add(0, 0, 0, 1, 1, 14, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1);
        // Backpressure in the even phase and in the odd phase.
        add(1, 1, 100, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 1, 77, 0, 1, 100, 0, 0, 0);
        add(0, 0, 0, 1, 1, 100, 0, 0, 0);
        add(0, 1, 55, 0, 1, 200, 1, 0, 0);
        add(0, 1, 55, 0, 1, 200, 1, 0, 0);
        add(0, 0, 0, 1, 1, 200, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1);
        // Positive saturation.
        add(1, 1, 30000, 1, 0, 0, 0, 0, 1);
        add(0, 1, 30000, 1, 1, 30000, 0, 0, 0);
        add(0, 1, 30000, 1, 1, 32767, 1, 1, 1);
        add(0, 0, 0, 1, 1, 32767, 0, 1, 0);
        add(0, 0, 0, 1, 1, 32767, 1, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1);
        // Negative saturation.
        add(1, 1, -30000, 1, 0, 0, 0, 0, 1);
        add(0, 1, -30000, 1, 1, -30000, 0, 0, 0);
        add(0, 1, -30000, 1, 1, -32768, 1, 1, 1);
        add(0, 0, 0, 1, 1, -32768, 0, 1, 0);
        add(0, 0, 0, 1, 1, -32768, 1, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 1);

        do_reset();
        foreach (vt[i]) begin
            if (vt[i].rb) do_reset();
            step(vt[i].iv, vt[i].din, vt[i].ordy);
            chk_out($sformatf("vec%0d", i), 1'b0, vt[i].ev, vt[i].ed, vt[i].eph,
                    vt[i].es, vt[i].eir);
        end

        // Reset while the odd sample is pending.
        do_reset();
        step(1, 100, 1); chk_out("rmid.acc", 1'b0, 0, 0, 0, 0, 1);
        step(0, 0, 1);   chk_out("rmid.even", 1'b0, 1, 100, 0, 0, 0);
        step(0, 0, 0);   chk_out("rmid.odd", 1'b0, 1, 200, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rmid.async.out_valid", out_valid_a, 0);
        chk("rmid.async.out_data", out_data_a, 0);
        chk("rmid.async.in_ready", in_ready_a, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1);
            chk_out("rmid.gone", 1'b0, 0, 0, 0, 0, 1);
        end
        step(1, 5, 1); chk_out("rmid.acc5", 1'b0, 0, 0, 0, 0, 1);
        step(0, 0, 1); chk_out("rmid.y0", 1'b0, 1, 5, 0, 0, 0);
        step(0, 0, 1); chk_out("rmid.y1", 1'b0, 1, 10, 1, 0, 1);
        step(0, 0, 1); chk_out("rmid.idle", 1'b0, 0, 0, 0, 0, 1);

        // SHIFT=2 instance with idle gaps: 7 then -8 gives 1, 3, 3, 3.
        do_reset();
        step(1, 7, 1);  chk_out("sh2.acc7", 1'b1, 0, 0, 0, 0, 1);
        step(0, 0, 1);  chk_out("sh2.y0", 1'b1, 1, 1, 0, 0, 0);
        step(0, 0, 1);  chk_out("sh2.y1", 1'b1, 1, 3, 1, 0, 1);
        step(0, 0, 1);  chk_out("sh2.gap0", 1'b1, 0, 0, 0, 0, 1);
        step(0, 0, 1);  chk_out("sh2.gap1", 1'b1, 0, 0, 0, 0, 1);
        step(1, -8, 1); chk_out("sh2.acc-8", 1'b1, 0, 0, 0, 0, 1);
        step(0, 0, 1);  chk_out("sh2.y2", 1'b1, 1, 3, 0, 0, 0);
        step(0, 0, 1);  chk_out("sh2.y3", 1'b1, 1, 3, 1, 0, 1);
        step(0, 0, 1);  chk_out("sh2.idle", 1'b1, 0, 0, 0, 0, 1);

        // Randomized traffic against the reference model.
        do_reset();
        q.delete();
        xprev = 0;
        for (int i = 0; i < 1500; i++) begin
            bit          iv, r;
            int          d;
            logic [15:0] rv;
            iv = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                rv = 16'($urandom());
                d  = int'($signed(rv));
            end else begin
                d = int'($urandom_range(0, 400)) - 200;
            end
            step(iv, d, r);
            model_cycle(iv, d, r);
        end
        for (int k = 0; k < 8 && q.size() > 0; k++) begin
            step(0, 0, 1);
            model_cycle(1'b0, 0, 1'b1);
        end
        chk("rnd.drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
